// File: rtl/rob_ptr_ctrl.sv
// Reorder-buffer head/tail pointer controller.
// Tracks the oldest entry (head), the next free slot (tail) and an explicit
// occupancy count so that full and empty stay unambiguous when head == tail.
// Supports multi-entry allocation and retirement per cycle, branch rollback
// of the tail and a full-window flush.
module rob_ptr_ctrl #(
  parameter int ROBsize     = 16,
  parameter int addrSize    = $clog2(ROBsize),
  parameter int allocWidth  = 2,
  parameter int commitWidth = 2,
  localparam int ACW = $clog2(allocWidth + 1),
  localparam int CCW = $clog2(commitWidth + 1),
  localparam int CW  = addrSize + 1
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [ACW-1:0]                 allocCnt_i,
  input  logic [CCW-1:0]                 commitCnt_i,
  input  logic                           rollback_i,
  input  logic [addrSize-1:0]            rollbackIdx_i,
  input  logic                           flush_i,
  output logic [addrSize-1:0]            head_o,
  output logic [addrSize-1:0]            tail_o,
  output logic [allocWidth*addrSize-1:0] allocIdx_o,
  output logic [CW-1:0]                  count_o,
  output logic [CW-1:0]                  freeCnt_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic                           stall_o
);

  localparam logic [CW-1:0] DEPTH = CW'(ROBsize);

  logic [addrSize-1:0] head_q, head_d;
  logic [addrSize-1:0] tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;
  logic                full_q, full_d;
  logic                empty_q, empty_d;

  logic [CW-1:0]       alloc_ext;
  logic [CW-1:0]       commit_ext;
  logic [CW-1:0]       eff_commit;
  logic [CW-1:0]       alloc_acc;
  logic [CW-1:0]       free_cnt;
  logic [addrSize-1:0] rb_off;
  logic [CW-1:0]       rb_off_ext;
  logic [addrSize-1:0] head_adv;
  logic                stall;

  // Request decode: clamp the commit to what is occupied and decide whether
  // the allocation fits in the space left by the registered count.
  always_comb begin
    alloc_ext  = CW'(allocCnt_i);
    commit_ext = CW'(commitCnt_i);
    free_cnt   = DEPTH - count_q;
    eff_commit = (commit_ext < count_q) ? commit_ext : count_q;
    stall      = (alloc_ext > free_cnt) & ~flush_i & ~rollback_i;
    alloc_acc  = (stall | flush_i | rollback_i) ? '0 : alloc_ext;
    rb_off     = rollbackIdx_i - head_q;
    rb_off_ext = {1'b0, rb_off};
    head_adv   = head_q + eff_commit[addrSize-1:0];
  end

  // Next-state: flush beats rollback, rollback beats normal alloc/commit.
  // An unoccupied rollback index is ignored and only the commit is applied.
  always_comb begin
    head_d  = head_adv;
    tail_d  = tail_q;
    count_d = count_q - eff_commit;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (rollback_i) begin
      if (rb_off_ext >= count_q) begin
        tail_d = tail_q;
      end else if (rb_off_ext < eff_commit) begin
        // Surviving entry retires this cycle, so the window becomes empty.
        tail_d  = head_adv;
        count_d = '0;
      end else begin
        tail_d  = rollbackIdx_i + addrSize'(1);
        count_d = rb_off_ext + CW'(1) - eff_commit;
      end
    end else begin
      tail_d  = tail_q + alloc_acc[addrSize-1:0];
      count_d = count_q + alloc_acc - eff_commit;
    end
    full_d  = (count_d == DEPTH);
    empty_d = (count_d == '0);
  end

  // Pointer, count and status registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Allocation slot indices: consecutive entries starting at the tail.
  always_comb begin
    allocIdx_o = '0;
    for (int k = 0; k < allocWidth; k++) begin
      allocIdx_o[k*addrSize +: addrSize] = tail_q + addrSize'(k);
    end
  end

  assign head_o    = head_q;
  assign tail_o    = tail_q;
  assign count_o   = count_q;
  assign freeCnt_o = free_cnt;
  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign stall_o   = stall;

endmodule
